// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI types for the master, slave wrapper and bench models.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_pkg;

  localparam int FRAME_W = 11;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    SPI_WR_ADDR = 2'b00,
    SPI_WR_DATA = 2'b01,
    SPI_RD_ADDR = 2'b10,
    SPI_RD_DATA = 2'b11
  } spi_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    DONE  = 3'd5
  } spi_state_e;

  // The op MSB is repeated in front of the op so the slave can tell
  // read from write on the very first bit it sees.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] op,
                                                    input logic [DATA_W-1:0] dat);
    return {op[1], op, dat};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bundle of the SPI master.
// Latency: wires only.
// Backpressure: cmd_valid/cmd_ready; rsp_valid is an unthrottled pulse.
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  // Host / CPU side.
  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  // SPI controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_master_ctrl_shift.sv
// Generic shift register: parallel load, shift left taking i_ser_in at the LSB.
// Latency: 1 cycle from load/shift to o_q.
// Backpressure: none; load wins over shift.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_dat,
  input  logic         i_shift,
  input  logic         i_ser_in,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Load takes priority; otherwise shift MSB-first when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_q <= '0;
    else if (i_load)  r_q <= i_load_dat;
    else if (i_shift) r_q <= {r_q[W-2:0], i_ser_in};
  end

  assign o_q = r_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns host op+byte commands into 11-bit frames, captures rd-data replies.
// Latency: cmd_ready returns 12+GAP_CYC cycles after accept (20+MISO_DLY+GAP_CYC for rd-data).
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, never queued.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int MISO_DLY = 2,  // 1..7
  parameter int GAP_CYC  = 1   // 1..7
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave host,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_SEND  = SEND;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_RECV  = RECV;
  localparam logic [2:0] S_DONE  = DONE;

  localparam logic [3:0] CNT_SEND = 4'(FRAME_W - 1);
  localparam logic [3:0] CNT_WAIT = 4'(MISO_DLY - 1);
  localparam logic [3:0] CNT_RECV = 4'(DATA_W - 1);
  localparam logic [3:0] CNT_DONE = 4'(GAP_CYC - 1);

  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_op;
  logic              r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_dat;

  logic               w_accept;
  logic               w_cnt_zero;
  logic [FRAME_W-1:0] w_tx_q;
  logic [DATA_W-1:0]  w_rx_q;
  logic               w_unused;

  assign w_accept   = host.cmd_valid && (r_state == S_IDLE);
  assign w_cnt_zero = (r_cnt == 4'd0);

  // TX path: frame latched at accept, shifted once per SEND cycle.
  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_load_dat(make_frame(host.cmd_op, host.cmd_data)),
    .i_shift   (r_state == S_SEND),
    .i_ser_in  (1'b0),
    .o_q       (w_tx_q)
  );

  // RX path: MISO is only looked at in RECV, so X/Z elsewhere never enters.
  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (1'b0),
    .i_load_dat('0),
    .i_shift   (r_state == S_RECV),
    .i_ser_in  (MISO),
    .o_q       (w_rx_q)
  );

  // Only the TX MSB is driven out, and the RX MSB is shifted past on the last sample.
  assign w_unused = ^{w_tx_q[FRAME_W-2:0], w_rx_q[DATA_W-1]};

  // Frame sequencer: one shared down-counter, loaded on state entry, moves on at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_op      <= SPI_WR_ADDR;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_START;
            r_op    <= host.cmd_op;
          end
        end
        S_START: begin
          r_state <= S_SEND;
          r_cnt   <= CNT_SEND;
        end
        S_SEND: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (r_op == SPI_RD_DATA) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_WAIT;
          end else begin
            r_state <= S_DONE;
            r_cnt   <= CNT_DONE;
          end
        end
        S_WAIT: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RECV;
            r_cnt   <= CNT_RECV;
          end
        end
        S_RECV: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // The 8th bit is captured straight from MISO on the same edge.
            r_rsp_dat <= {w_rx_q[DATA_W-2:0], MISO};
            r_rsp_vld <= 1'b1;
            r_state   <= S_DONE;
            r_cnt     <= CNT_DONE;
          end
        end
        S_DONE: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 4'd1;
          else             r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign SS_n           = (r_state == S_IDLE) || (r_state == S_DONE);
  assign MOSI           = (r_state == S_SEND) ? w_tx_q[FRAME_W-1] : 1'b0;
  assign host.cmd_ready = (r_state == S_IDLE);
  assign host.busy      = (r_state != S_IDLE);
  assign host.rsp_valid = r_rsp_vld;
  assign host.rsp_data  = r_rsp_dat;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with hand-computed frame bit streams.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int D = 2;  // MISO_DLY
  localparam int G = 1;  // GAP_CYC

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n, MOSI, MISO;
  int   n_vec = 0;
  int   n_err = 0;

  spi_master_ctrl_if bus();

  spi_master_ctrl #(.MISO_DLY(D), .GAP_CYC(G)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (bus),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [7:0] dat);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = dat;
  endtask

  // Runs one frame from the accept edge to cmd_ready reasserting.
  // A command must already be presented with cmd_ready high.
  task automatic do_frame(input logic [1:0] op, input logic [10:0] exp_bits,
                          input logic [7:0] miso_byte, input bit jitter,
                          input logic nxt_vld, input logic [1:0] nxt_op,
                          input logic [7:0] nxt_dat);
    chk("pre_ready", 11'(bus.cmd_ready), 11'd1);
    tick();  // E0: accept
    bus.cmd_valid = nxt_vld;
    bus.cmd_op    = nxt_op;
    bus.cmd_data  = nxt_dat;
    chk("start_ss", 11'(SS_n), 11'd0);
    chk("start_mosi", 11'(MOSI), 11'd0);
    chk("start_busy", 11'(bus.busy), 11'd1);
    chk("start_ready", 11'(bus.cmd_ready), 11'd0);
    for (int k = 1; k <= 11; k++) begin
      if (jitter) begin
        bus.cmd_valid = ~bus.cmd_valid;
        bus.cmd_data  = 8'($urandom);
        bus.cmd_op    = 2'($urandom);
      end
      tick();
      chk($sformatf("send_mosi_b%0d", k), 11'(MOSI), 11'(exp_bits[11-k]));
      chk("send_ss", 11'(SS_n), 11'd0);
      chk("send_ready", 11'(bus.cmd_ready), 11'd0);
    end
    bus.cmd_valid = nxt_vld;
    bus.cmd_op    = nxt_op;
    bus.cmd_data  = nxt_dat;
    tick();  // E12
    if (op == 2'b11) begin
      chk("wait_ss", 11'(SS_n), 11'd0);
      chk("wait_mosi", 11'(MOSI), 11'd0);
      MISO = 1'bx;
      for (int w = 0; w < D; w++) begin
        tick();
        chk("wait_ss2", 11'(SS_n), 11'd0);
        chk("wait_mosi2", 11'(MOSI), 11'd0);
      end
      for (int i = 0; i < 8; i++) begin
        MISO = miso_byte[7-i];
        tick();
        if (i < 7) begin
          chk("recv_ss", 11'(SS_n), 11'd0);
          chk("recv_rsp_vld", 11'(bus.rsp_valid), 11'd0);
        end
      end
      MISO = 1'bx;
      chk("rsp_valid", 11'(bus.rsp_valid), 11'd1);
      chk("rsp_data", 11'(bus.rsp_data), 11'(miso_byte));
      chk("rsp_ss", 11'(SS_n), 11'd1);
    end else begin
      chk("done_ss", 11'(SS_n), 11'd1);
      chk("done_mosi", 11'(MOSI), 11'd0);
      chk("done_rsp_vld", 11'(bus.rsp_valid), 11'd0);
    end
    chk("done_ready", 11'(bus.cmd_ready), 11'd0);
    for (int g = 1; g < G; g++) begin
      tick();
      chk("gap_ready", 11'(bus.cmd_ready), 11'd0);
    end
    tick();  // back to IDLE
    chk("idle_ready", 11'(bus.cmd_ready), 11'd1);
    chk("idle_ss", 11'(SS_n), 11'd1);
    chk("idle_rsp_vld", 11'(bus.rsp_valid), 11'd0);
    if (op == 2'b11) chk("rsp_hold", 11'(bus.rsp_data), 11'(miso_byte));
  endtask

  initial begin
    int pulses;
    // Reset with cmd_valid asserted: nothing may be accepted.
    rst_n         = 1'b0;
    MISO          = 1'b0;
    present(SPI_WR_ADDR, 8'h3C);
    tick();
    tick();
    chk("rst_ss", 11'(SS_n), 11'd1);
    chk("rst_mosi", 11'(MOSI), 11'd0);
    chk("rst_ready", 11'(bus.cmd_ready), 11'd1);
    chk("rst_busy", 11'(bus.busy), 11'd0);
    chk("rst_rsp_vld", 11'(bus.rsp_valid), 11'd0);
    chk("rst_rsp_dat", 11'(bus.rsp_data), 11'd0);
    bus.cmd_valid = 1'b0;
    rst_n         = 1'b1;
    tick();
    chk("post_rst_busy", 11'(bus.busy), 11'd0);

    // wr-addr 0x3C: 0,00,0011_1100
    present(SPI_WR_ADDR, 8'h3C);
    do_frame(2'b00, 11'b000_0011_1100, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);

    // rd-data 0x00 with the slave replying 0xA5
    present(SPI_RD_DATA, 8'h00);
    do_frame(2'b11, 11'b111_0000_0000, 8'hA5, 1'b0, 1'b0, 2'b00, 8'h00);

    // Back-to-back: wr-data 0xFF then rd-addr 0x81, cmd_valid held high
    present(SPI_WR_DATA, 8'hFF);
    do_frame(2'b01, 11'b001_1111_1111, 8'h00, 1'b0, 1'b1, 2'b10, 8'h81);
    do_frame(2'b10, 11'b110_1000_0001, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);

    // wr-addr 0x96 with cmd_valid/cmd_data/cmd_op churning during SEND
    present(SPI_WR_ADDR, 8'h96);
    do_frame(2'b00, 11'b000_1001_0110, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
    chk("jitter_busy", 11'(bus.busy), 11'd0);

    // Reset in the middle of RECV
    present(SPI_RD_DATA, 8'h00);
    tick();  // E0
    bus.cmd_valid = 1'b0;
    repeat (12 + D) tick();
    chk("mid_ss", 11'(SS_n), 11'd0);
    MISO = 1'b1; tick();
    MISO = 1'b0; tick();
    MISO = 1'b1; tick();
    MISO = 1'b0; tick();
    chk("mid_ss2", 11'(SS_n), 11'd0);
    chk("mid_rsp_vld", 11'(bus.rsp_valid), 11'd0);
    rst_n = 1'b0;
    tick();
    chk("abort_ss", 11'(SS_n), 11'd1);
    chk("abort_rsp_vld", 11'(bus.rsp_valid), 11'd0);
    chk("abort_rsp_dat", 11'(bus.rsp_data), 11'd0);
    chk("abort_ready", 11'(bus.cmd_ready), 11'd1);
    rst_n  = 1'b1;
    MISO   = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.rsp_valid === 1'b1 || SS_n !== 1'b1) pulses++;
    end
    chk("abort_no_resume", 11'(pulses), 11'd0);

    // Following rd-data 0x5A completes normally, slave replies 0x3C
    present(SPI_RD_DATA, 8'h5A);
    do_frame(2'b11, 11'b111_0101_1010, 8'h3C, 1'b0, 1'b0, 2'b00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
